// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ack bus between the fetch unit and instruction memory.
//   imem_req   : fetch request, driven by the fetch unit (master)
//   imem_addr  : word-aligned fetch address, driven by the fetch unit
//   imem_ack   : memory completes the request this cycle, driven by memory (slave)
//   imem_rdata : instruction word, valid with imem_ack, driven by memory
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, runs the ack-based handshake
// with instruction memory and buffers fetched words in an in-order queue that
// feeds the ID stage. EXE branch redirects flush the queue.
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   freeze        : ID hazard stall, hold the presented instruction
//   branch_taken  : redirect from EXE (wins over freeze and imem_ack)
//   branch_addr   : word-aligned redirect target
//   imem          : instruction memory bus (fetch_unit_if.master)
//   valid         : Instruction/PC valid to ID
//   Instruction   : queue head instruction, 0 when !valid
//   PC            : queue head address + 4, 0 when !valid
//
// Optional build macro FETCH_PERF_CNT_EN adds two saturating counters:
//   stall_cycles (32b) : cycles with imem_req && !imem_ack
//   flush_count  (16b) : cycles with branch_taken
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                branch_taken,
    input  logic [31:0]         branch_addr,
    fetch_unit_if.master        imem,
    output logic                valid,
    output logic [31:0]         Instruction,
    output logic [31:0]         PC
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         stall_cycles,
    output logic [15:0]         flush_count
`endif
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    // Architectural state
    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  q_pc_q    [DEPTH];
    logic [XLEN-1:0]  q_pc_d    [DEPTH];
    logic [XLEN-1:0]  q_instr_q [DEPTH];
    logic [XLEN-1:0]  q_instr_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic imem_req_c;
    logic valid_c;
    logic enq_c;
    logic deq_c;

    // Handshake qualifiers; a redirect drops the request in the same cycle
    assign imem_req_c = !rst && !branch_taken && (count_q < CNT_W'(DEPTH));
    assign enq_c      = imem_req_c && imem.imem_ack;
    assign valid_c    = (count_q != '0);
    assign deq_c      = valid_c && !freeze && !branch_taken;

    assign imem.imem_req  = imem_req_c;
    assign imem.imem_addr = fetch_pc_q;

    // Head of queue to ID, forced to zero when empty so stale entries never leak
    assign valid       = valid_c;
    assign Instruction = valid_c ? q_instr_q[rd_ptr_q] : '0;
    assign PC          = valid_c ? q_pc_q[rd_ptr_q]    : '0;

    // Next-state: queue push/pop, fetch PC advance, redirect flush
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        q_pc_d     = q_pc_q;
        q_instr_d  = q_instr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (branch_taken) begin
            fetch_pc_d = branch_addr;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (enq_c) begin
                // Stored PC is the fetch address + 4; the add wraps at 2^32
                q_pc_d[wr_ptr_q]    = fetch_pc_q + XLEN'(4);
                q_instr_d[wr_ptr_q] = imem.imem_rdata;
                wr_ptr_d            = wr_ptr_q + PTR_W'(1);
                fetch_pc_d          = fetch_pc_q + XLEN'(4);
            end
            if (deq_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({enq_c, deq_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                q_pc_q[i]    <= '0;
                q_instr_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            q_pc_q     <= q_pc_d;
            q_instr_q  <= q_instr_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] flush_count_q, flush_count_d;

    // Saturating performance counters
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (imem_req_c && !imem.imem_ack && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'(1);
        end
        if (branch_taken && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + 16'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, zero-wait streaming, wait states,
// freeze with full queue, redirects (with full queue, with freeze, with ack),
// fetch PC wrap and asynchronous reset mid-stream.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        br;
    logic [31:0] br_addr;
    logic        ack_drv;
    logic        valid;
    logic [31:0] Instruction;
    logic [31:0] PC;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    fetch_unit_if bus();

    // Memory word derived from its address so every fetch is distinguishable
    function automatic logic [31:0] w(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    assign bus.imem_ack   = ack_drv;
    assign bus.imem_rdata = w(bus.imem_addr);

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (br),
        .branch_addr  (br_addr),
        .imem         (bus),
        .valid        (valid),
        .Instruction  (Instruction),
        .PC           (PC)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_ins);
        chk({tag, "_valid"}, 32'(valid), 32'd1);
        chk({tag, "_pc"},    PC,          exp_pc);
        chk({tag, "_instr"}, Instruction, exp_ins);
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_pc"},    PC,          32'd0);
        chk({tag, "_instr"}, Instruction, 32'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; freeze = 1'b0; br = 1'b0; br_addr = '0; ack_drv = 1'b0;
        tick(); tick();
        chk_empty("rst");
        chk("rst_req",  32'(bus.imem_req), 32'd0);
        chk("rst_addr", bus.imem_addr,     32'h0);

        // Zero-wait streaming from RESET_PC
        rst = 1'b0; ack_drv = 1'b1; #1;
        chk("c1_req",  32'(bus.imem_req), 32'd1);
        chk("c1_addr", bus.imem_addr,     32'h0);
        chk_empty("c1");
        tick(); chk_head("c2", 32'h4, w(32'h0)); chk("c2_addr", bus.imem_addr, 32'h4);
        tick(); chk_head("c3", 32'h8, w(32'h4));
        tick(); chk_head("c4", 32'hC, w(32'h8)); chk("c4_addr", bus.imem_addr, 32'hC);

        // Three wait states at 0x10
        tick(); chk_head("c5", 32'h10, w(32'hC));
        ack_drv = 1'b0; #1;
        chk("c5_addr", bus.imem_addr, 32'h10);
        chk("c5_req",  32'(bus.imem_req), 32'd1);
        tick(); chk_empty("c6"); chk("c6_addr", bus.imem_addr, 32'h10); chk("c6_req", 32'(bus.imem_req), 32'd1);
        tick(); chk_empty("c7"); chk("c7_addr", bus.imem_addr, 32'h10);
        tick(); chk_empty("c8"); chk("c8_addr", bus.imem_addr, 32'h10); chk("c8_req", 32'(bus.imem_req), 32'd1);
        ack_drv = 1'b1;
        tick(); chk_head("c9", 32'h14, w(32'h10)); chk("c9_addr", bus.imem_addr, 32'h14);

        // Freeze for four cycles: queue fills, request drops, head held
        freeze = 1'b1;
        tick(); chk_head("c10", 32'h14, w(32'h10)); chk("c10_req", 32'(bus.imem_req), 32'd0);
        tick(); chk_head("c11", 32'h14, w(32'h10));
        tick(); chk_head("c12", 32'h14, w(32'h10)); chk("c12_req", 32'(bus.imem_req), 32'd0);
        tick(); chk_head("c13", 32'h14, w(32'h10)); chk("c13_req", 32'(bus.imem_req), 32'd0);
        freeze = 1'b0;
        tick(); chk_head("c14", 32'h18, w(32'h14));
        chk("c14_req",  32'(bus.imem_req), 32'd1);
        chk("c14_addr", bus.imem_addr,     32'h18);
        tick(); chk_head("c15", 32'h1C, w(32'h18));

        // Fill the queue, then redirect with freeze and ack both high
        freeze = 1'b1;
        tick(); chk_head("c16", 32'h1C, w(32'h18));
        chk("c16_req",  32'(bus.imem_req), 32'd0);
        chk("c16_addr", bus.imem_addr,     32'h20);
        br = 1'b1; br_addr = 32'h100; #1;
        chk("c16_br_req", 32'(bus.imem_req), 32'd0);
        tick(); chk_empty("c17"); chk("c17_addr", bus.imem_addr, 32'h100);
        br = 1'b0; freeze = 1'b0; #1;
        chk("c17_req", 32'(bus.imem_req), 32'd1);
        tick(); chk_head("c18", 32'h104, w(32'h100));

        // Redirect with ack high and a non-full queue
        br = 1'b1; br_addr = 32'h200; #1;
        chk("c18_br_req", 32'(bus.imem_req), 32'd0);
        tick(); chk_empty("c19"); chk("c19_addr", bus.imem_addr, 32'h200);
        br = 1'b0;
        tick(); chk_head("c20", 32'h204, w(32'h200));

        // Fetch PC wrap at the top of the address space
        br = 1'b1; br_addr = 32'hFFFF_FFFC;
        tick(); chk_empty("c21"); chk("c21_addr", bus.imem_addr, 32'hFFFF_FFFC);
        br = 1'b0;
        tick(); chk_head("c22", 32'h0, w(32'hFFFF_FFFC)); chk("c22_addr", bus.imem_addr, 32'h0);
        tick(); chk_head("c23", 32'h4, w(32'h0)); chk("c23_addr", bus.imem_addr, 32'h4);

        // Asynchronous reset between clock edges
        #2 rst = 1'b1;
        #1;
        chk_empty("arst");
        chk("arst_req",  32'(bus.imem_req), 32'd0);
        chk("arst_addr", bus.imem_addr,     32'h0);
        tick();
        rst = 1'b0; #1;
        chk("rel_req",  32'(bus.imem_req), 32'd1);
        chk("rel_addr", bus.imem_addr,     32'h0);
        chk_empty("rel");
        tick(); chk_head("rel2", 32'h4, w(32'h0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
